// File: rtl/sys_cmd_decoder_pkg.sv
// Shared constants for the UART command-frame decoder: byte width, command codes,
// FSM state encoding and the fixed operand register addresses.
package sys_cmd_decoder_pkg;

  localparam int WIDTH = 8;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int REG_OPA = 0;
  localparam int REG_OPB = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_OP_A,
    ST_OP_B,
    ST_ALU_FUN
  } state_t;

endpackage

// File: rtl/sys_cmd_decoder.sv
// Parses synchronized UART command frames into one-cycle register-file and ALU strobes.
// Every output is a flop; payload bytes are never interpreted as commands.
module sys_cmd_decoder #(
  parameter int WIDTH      = sys_cmd_decoder_pkg::WIDTH,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [WIDTH-1:0]      i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_rf_wr_en,
  output logic                  o_rf_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rf_addr,
  output logic [WIDTH-1:0]      o_rf_wr_data,
  output logic                  o_alu_en,
  output logic [FUN_WIDTH-1:0]  o_alu_fun,
  output logic                  o_frame_err,
  output logic                  o_busy
);
  import sys_cmd_decoder_pkg::*;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_lat;
  logic [7:0]            cmd_byte;

  assign cmd_byte = i_rx_data[7:0];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state        <= ST_IDLE;
      addr_lat     <= '0;
      o_rf_wr_en   <= 1'b0;
      o_rf_rd_en   <= 1'b0;
      o_rf_addr    <= '0;
      o_rf_wr_data <= '0;
      o_alu_en     <= 1'b0;
      o_alu_fun    <= '0;
      o_frame_err  <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      // Strobes default low; qualified data outputs keep their last value.
      o_rf_wr_en  <= 1'b0;
      o_rf_rd_en  <= 1'b0;
      o_alu_en    <= 1'b0;
      o_frame_err <= 1'b0;
      if (i_rx_valid) begin
        case (state)
          ST_IDLE: begin
            case (cmd_byte)
              CMD_WR: begin
                state  <= ST_WR_ADDR;
                o_busy <= 1'b1;
              end
              CMD_RD: begin
                state  <= ST_RD_ADDR;
                o_busy <= 1'b1;
              end
              CMD_ALU_OP: begin
                state  <= ST_OP_A;
                o_busy <= 1'b1;
              end
              CMD_ALU_NOP: begin
                state  <= ST_ALU_FUN;
                o_busy <= 1'b1;
              end
              default: o_frame_err <= 1'b1;
            endcase
          end
          ST_WR_ADDR: begin
            addr_lat <= i_rx_data[ADDR_WIDTH-1:0];
            state    <= ST_WR_DATA;
          end
          ST_WR_DATA: begin
            o_rf_wr_en   <= 1'b1;
            o_rf_addr    <= addr_lat;
            o_rf_wr_data <= i_rx_data;
            state        <= ST_IDLE;
            o_busy       <= 1'b0;
          end
          ST_RD_ADDR: begin
            o_rf_rd_en <= 1'b1;
            o_rf_addr  <= i_rx_data[ADDR_WIDTH-1:0];
            state      <= ST_IDLE;
            o_busy     <= 1'b0;
          end
          ST_OP_A: begin
            o_rf_wr_en   <= 1'b1;
            o_rf_addr    <= ADDR_WIDTH'(REG_OPA);
            o_rf_wr_data <= i_rx_data;
            state        <= ST_OP_B;
          end
          ST_OP_B: begin
            o_rf_wr_en   <= 1'b1;
            o_rf_addr    <= ADDR_WIDTH'(REG_OPB);
            o_rf_wr_data <= i_rx_data;
            state        <= ST_ALU_FUN;
          end
          ST_ALU_FUN: begin
            o_alu_en  <= 1'b1;
            o_alu_fun <= i_rx_data[FUN_WIDTH-1:0];
            state     <= ST_IDLE;
            o_busy    <= 1'b0;
          end
          default: begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sys_cmd_decoder.sv
// Directed vector table, hand-built reset/gap sequences and a randomized run
// compared against a frame-level reference model.
module tb_sys_cmd_decoder;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rf_wr_en;
  logic       rf_rd_en;
  logic [3:0] rf_addr;
  logic [7:0] rf_wr_data;
  logic       alu_en;
  logic [3:0] alu_fun;
  logic       frame_err;
  logic       busy;

  sys_cmd_decoder #(.WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4)) dut (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .o_rf_wr_en   (rf_wr_en),
    .o_rf_rd_en   (rf_rd_en),
    .o_rf_addr    (rf_addr),
    .o_rf_wr_data (rf_wr_data),
    .o_alu_en     (alu_en),
    .o_alu_fun    (alu_fun),
    .o_frame_err  (frame_err),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       wr;
    logic       rd;
    logic       alu;
    logic       err;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [3:0] fun;
    logic       busy;
  } obs_t;

  typedef struct {
    logic       v;
    logic [7:0] d;
    obs_t       e;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  int   step_no = 0;
  obs_t mexp;
  logic [7:0] frame_q[$];
  vec_t vecs[20];

  function automatic obs_t mk(logic wr, logic rd, logic alu, logic err,
                              logic [3:0] addr, logic [7:0] wdata,
                              logic [3:0] fun, logic bsy);
    obs_t o;
    o.wr = wr; o.rd = rd; o.alu = alu; o.err = err;
    o.addr = addr; o.wdata = wdata; o.fun = fun; o.busy = bsy;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    return mk(rf_wr_en, rf_rd_en, alu_en, frame_err, rf_addr, rf_wr_data, alu_fun, busy);
  endfunction

  task automatic check(input string name, input obs_t exp);
    obs_t got;
    got = dut_obs();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got(wr rd alu err addr wdata fun busy)=%b %b %b %b %h %h %h %b exp=%b %b %b %b %h %h %h %b",
               name, step_no, got.wr, got.rd, got.alu, got.err, got.addr, got.wdata, got.fun, got.busy,
               exp.wr, exp.rd, exp.alu, exp.err, exp.addr, exp.wdata, exp.fun, exp.busy);
    end else begin
      $display("ok   %s step=%0d wr=%b rd=%b alu=%b err=%b addr=%h wdata=%h fun=%h busy=%b",
               name, step_no, got.wr, got.rd, got.alu, got.err, got.addr, got.wdata, got.fun, got.busy);
    end
  endtask

  // Frame-level reference: collect bytes of the current frame and act on frame length.
  task automatic model_reset();
    frame_q.delete();
    mexp = mk(0, 0, 0, 0, 4'h0, 8'h00, 4'h0, 0);
  endtask

  task automatic model_byte(input logic v, input logic [7:0] d);
    logic [7:0] c, b1, b2, b3;
    int n;
    logic done;
    mexp.wr = 0; mexp.rd = 0; mexp.alu = 0; mexp.err = 0;
    done = 0;
    if (v) begin
      if (frame_q.size() == 0) begin
        if (d == 8'hAA || d == 8'hBB || d == 8'hCC || d == 8'hDD) frame_q.push_back(d);
        else mexp.err = 1;
      end else begin
        frame_q.push_back(d);
        n = frame_q.size();
        c = frame_q[0];
        b1 = frame_q[1];
        b2 = (n > 2) ? frame_q[2] : 8'h00;
        b3 = (n > 3) ? frame_q[3] : 8'h00;
        if (c == 8'hAA && n == 3) begin
          mexp.wr = 1; mexp.addr = b1[3:0]; mexp.wdata = b2; done = 1;
        end else if (c == 8'hBB) begin
          mexp.rd = 1; mexp.addr = b1[3:0]; done = 1;
        end else if (c == 8'hCC) begin
          if (n == 2) begin mexp.wr = 1; mexp.addr = 4'd0; mexp.wdata = b1; end
          else if (n == 3) begin mexp.wr = 1; mexp.addr = 4'd1; mexp.wdata = b2; end
          else begin mexp.alu = 1; mexp.fun = b3[3:0]; done = 1; end
        end else if (c == 8'hDD) begin
          mexp.alu = 1; mexp.fun = b1[3:0]; done = 1;
        end
        if (done) frame_q.delete();
      end
    end
    mexp.busy = (frame_q.size() != 0);
  endtask

  // Called at a negedge: drive, let the next posedge sample, return at the following negedge.
  task automatic step(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    model_byte(v, d);
    step_no++;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    model_reset();

    vecs[0]  = '{1'b1, 8'hAA, mk(0,0,0,0,4'h0,8'h00,4'h0,1)};
    vecs[1]  = '{1'b0, 8'hAA, mk(0,0,0,0,4'h0,8'h00,4'h0,1)};
    vecs[2]  = '{1'b1, 8'h05, mk(0,0,0,0,4'h0,8'h00,4'h0,1)};
    vecs[3]  = '{1'b0, 8'h05, mk(0,0,0,0,4'h0,8'h00,4'h0,1)};
    vecs[4]  = '{1'b1, 8'h3C, mk(1,0,0,0,4'h5,8'h3C,4'h0,0)};
    vecs[5]  = '{1'b0, 8'h3C, mk(0,0,0,0,4'h5,8'h3C,4'h0,0)};
    vecs[6]  = '{1'b1, 8'hBB, mk(0,0,0,0,4'h5,8'h3C,4'h0,1)};
    vecs[7]  = '{1'b1, 8'h1F, mk(0,1,0,0,4'hF,8'h3C,4'h0,0)};
    vecs[8]  = '{1'b1, 8'hCC, mk(0,0,0,0,4'hF,8'h3C,4'h0,1)};
    vecs[9]  = '{1'b1, 8'h12, mk(1,0,0,0,4'h0,8'h12,4'h0,1)};
    vecs[10] = '{1'b1, 8'h34, mk(1,0,0,0,4'h1,8'h34,4'h0,1)};
    vecs[11] = '{1'b1, 8'h07, mk(0,0,1,0,4'h1,8'h34,4'h7,0)};
    vecs[12] = '{1'b0, 8'h00, mk(0,0,0,0,4'h1,8'h34,4'h7,0)};
    vecs[13] = '{1'b1, 8'hDD, mk(0,0,0,0,4'h1,8'h34,4'h7,1)};
    vecs[14] = '{1'b1, 8'h03, mk(0,0,1,0,4'h1,8'h34,4'h3,0)};
    vecs[15] = '{1'b1, 8'h55, mk(0,0,0,1,4'h1,8'h34,4'h3,0)};
    vecs[16] = '{1'b1, 8'hAA, mk(0,0,0,0,4'h1,8'h34,4'h3,1)};
    vecs[17] = '{1'b1, 8'h02, mk(0,0,0,0,4'h1,8'h34,4'h3,1)};
    vecs[18] = '{1'b1, 8'hAA, mk(1,0,0,0,4'h2,8'hAA,4'h3,0)};
    vecs[19] = '{1'b0, 8'h00, mk(0,0,0,0,4'h2,8'hAA,4'h3,0)};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", mk(0,0,0,0,4'h0,8'h00,4'h0,0));
    rst_n = 1'b1;
    step(1'b0, 8'h00);
    check("idle_after_reset", mk(0,0,0,0,4'h0,8'h00,4'h0,0));

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].v, vecs[i].d);
      check($sformatf("vec%0d", i), vecs[i].e);
    end

    // Reset while waiting for the write data byte.
    step(1'b1, 8'hAA);
    step(1'b1, 8'h04);
    check("pre_reset_busy", mk(0,0,0,0,4'h2,8'hAA,4'h3,1));
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    rst_n = 1'b0;
    #1;
    check("async_reset", mk(0,0,0,0,4'h0,8'h00,4'h0,0));
    @(posedge clk);
    @(negedge clk);
    check("held_reset", mk(0,0,0,0,4'h0,8'h00,4'h0,0));
    rst_n = 1'b1;
    model_reset();
    step(1'b0, 8'h00);
    check("post_reset_idle", mk(0,0,0,0,4'h0,8'h00,4'h0,0));
    step(1'b1, 8'hBB);
    check("post_reset_bb", mexp);
    step(1'b1, 8'h04);
    check("post_reset_read", mk(0,1,0,0,4'h4,8'h00,4'h0,0));

    // Long idle gaps inside a frame.
    step(1'b1, 8'hAA);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 8'hFF);
      check("gap1", mexp);
    end
    step(1'b1, 8'h07);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 8'hFF);
      check("gap2", mexp);
    end
    step(1'b1, 8'h99);
    check("gap_write", mk(1,0,0,0,4'h7,8'h99,4'h0,0));

    // Randomized stream, command codes favoured so frames actually form.
    for (int i = 0; i < 2000; i++) begin
      logic v;
      logic [7:0] d;
      v = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 9))
        0: d = 8'hAA;
        1: d = 8'hBB;
        2: d = 8'hCC;
        3: d = 8'hDD;
        default: d = 8'($urandom);
      endcase
      step(v, d);
      check("rand", mexp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
